// File: rtl/branch_predict_unit_pkg.sv
// Package core: shared pipeline types, ALU encodings and BTB entry layout
// used by branch_predict_unit and branch_target_buffer.
package core;

  localparam int unsigned CORE_XLEN        = 32;
  localparam int unsigned CORE_BTB_ENTRIES = 64;
  localparam int unsigned BTB_IDX_W        = $clog2(CORE_BTB_ENTRIES);
  localparam int unsigned BTB_TAG_W        = CORE_XLEN - BTB_IDX_W - 2;

  // alu_op[4:3] selects the instruction class
  localparam logic [1:0] BRANCH_PRFX = 2'b11;
  localparam logic [1:0] J_PRFX      = 2'b10;

  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_BEQ  = {BRANCH_PRFX, 3'b000};
  localparam logic [4:0] ALU_BNE  = {BRANCH_PRFX, 3'b001};
  localparam logic [4:0] ALU_BLT  = {BRANCH_PRFX, 3'b100};
  localparam logic [4:0] ALU_BGE  = {BRANCH_PRFX, 3'b101};
  localparam logic [4:0] ALU_BLTU = {BRANCH_PRFX, 3'b110};
  localparam logic [4:0] ALU_BGEU = {BRANCH_PRFX, 3'b111};
  localparam logic [4:0] ALU_JAL  = {J_PRFX, 3'b000};
  localparam logic [4:0] ALU_JALR = {J_PRFX, 3'b001};

  localparam logic [1:0] CNT_STRONG_NT = 2'b00;
  localparam logic [1:0] CNT_WEAK_NT   = 2'b01;
  localparam logic [1:0] CNT_WEAK_T    = 2'b10;
  localparam logic [1:0] CNT_STRONG_T  = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [CORE_XLEN-1:0] target;
    logic [1:0]           cnt;
  } btb_entry_t;

  typedef struct packed {
    logic                 is_branch;
    logic [4:0]           alu_op;
    logic [CORE_XLEN-1:0] pc;
    logic [CORE_XLEN-1:0] imm;
  } pipeline_bus_t;

  typedef struct packed {
    logic                 is_taken;
    logic [CORE_XLEN-1:0] branch_target;
  } br_cntrl_bus_t;

  // 2-bit saturating counter step
  function automatic logic [1:0] cnt_step(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == CNT_STRONG_T) ? CNT_STRONG_T : cnt + 2'b01;
    else       return (cnt == CNT_STRONG_NT) ? CNT_STRONG_NT : cnt - 2'b01;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB storage: combinational fetch read, combinational
// execute-side read for training, one synchronous write, synchronous reset.
module branch_target_buffer
  import core::*;
#(
  parameter int unsigned ENTRIES = CORE_BTB_ENTRIES,
  localparam int unsigned IW     = $clog2(ENTRIES)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [IW-1:0] lk_idx_i,
  output btb_entry_t    lk_entry_o,
  input  logic [IW-1:0] ex_idx_i,
  output btb_entry_t    ex_entry_o,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  btb_entry_t    wr_entry_i
);

  btb_entry_t mem_q [ENTRIES];

  // Reads see the pre-write contents during a same-cycle write
  assign lk_entry_o = mem_q[lk_idx_i];
  assign ex_entry_o = mem_q[ex_idx_i];

  // Storage update; reset returns every entry to invalid, weakly not-taken
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        mem_q[i] <= '{valid: 1'b0, tag: '0, target: '0, cnt: CNT_WEAK_NT};
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch-time BTB prediction plus execute-stage branch resolution,
// mispredict flush and BTB training. Optional statistics counters are
// enabled by defining BRU_STATS_EN.
module branch_predict_unit
  import core::*;
#(
  parameter int unsigned XLEN        = CORE_XLEN,
  parameter int unsigned BTB_ENTRIES = CORE_BTB_ENTRIES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              f_valid_i,
  input  logic [XLEN-1:0]   f_pc_i,
  output logic              pred_taken_o,
  output logic [XLEN-1:0]   pred_target_o,
  input  logic              ex_valid_i,
  input  logic              ex_stall_i,
  input  pipeline_bus_t     bus_i,
  input  logic              ex_pred_taken_i,
  input  logic [XLEN-1:0]   ex_pred_target_i,
  input  logic [XLEN-1:0]   rs1_in_i,
  input  logic [XLEN-1:0]   rs2_in_i,
  output logic [XLEN-1:0]   rd_o,
  output logic              flush_o,
  output br_cntrl_bus_t     br_bus_o
`ifdef BRU_STATS_EN
  ,
  output logic [31:0]       branch_cnt_o,
  output logic [31:0]       mispredict_cnt_o
`endif
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);

  btb_entry_t lk_entry, ex_entry, wr_entry;
  logic       wr_en;

  logic [IDX-1:0]        f_idx, ex_idx;
  logic [XLEN-IDX-3:0]   f_tag, ex_tag;
  logic                  f_hit, ex_hit;

  assign f_idx  = f_pc_i[IDX+1:2];
  assign f_tag  = f_pc_i[XLEN-1:IDX+2];
  assign ex_idx = bus_i.pc[IDX+1:2];
  assign ex_tag = bus_i.pc[XLEN-1:IDX+2];

  branch_target_buffer #(
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .lk_idx_i   (f_idx),
    .lk_entry_o (lk_entry),
    .ex_idx_i   (ex_idx),
    .ex_entry_o (ex_entry),
    .wr_en_i    (wr_en),
    .wr_idx_i   (ex_idx),
    .wr_entry_i (wr_entry)
  );

  // Fetch-side prediction
  assign f_hit         = lk_entry.valid && (lk_entry.tag == f_tag);
  assign pred_taken_o  = f_valid_i && !rst_i && f_hit && lk_entry.cnt[1];
  assign pred_target_o = pred_taken_o ? lk_entry.target : f_pc_i + XLEN'(4);

  logic            act_taken, is_jump, mispredict, ex_active, train;
  logic [XLEN-1:0] act_target, next_pc, link_pc;

  // Resolve the execute-stage instruction; unknown branch-class ops fall through not-taken
  always_comb begin
    act_taken  = 1'b0;
    is_jump    = 1'b0;
    act_target = bus_i.pc + bus_i.imm;
    if (bus_i.is_branch) begin
      case (bus_i.alu_op)
        ALU_BEQ:  act_taken = (rs1_in_i == rs2_in_i);
        ALU_BNE:  act_taken = (rs1_in_i != rs2_in_i);
        ALU_BLT:  act_taken = ($signed(rs1_in_i) <  $signed(rs2_in_i));
        ALU_BGE:  act_taken = ($signed(rs1_in_i) >= $signed(rs2_in_i));
        ALU_BLTU: act_taken = (rs1_in_i <  rs2_in_i);
        ALU_BGEU: act_taken = (rs1_in_i >= rs2_in_i);
        ALU_JAL: begin
          act_taken = 1'b1;
          is_jump   = 1'b1;
        end
        ALU_JALR: begin
          act_taken  = 1'b1;
          is_jump    = 1'b1;
          act_target = (rs1_in_i + bus_i.imm) & ~XLEN'(1);
        end
        default: act_taken = 1'b0;
      endcase
    end
  end

  assign link_pc    = bus_i.pc + XLEN'(4);
  assign next_pc    = act_taken ? act_target : link_pc;
  assign mispredict = (act_taken != ex_pred_taken_i) ||
                      (act_taken && (act_target != ex_pred_target_i));
  assign ex_active  = ex_valid_i && bus_i.is_branch && !rst_i;
  assign train      = ex_active && !ex_stall_i;

  assign flush_o                = mispredict && ex_active;
  assign br_bus_o.is_taken      = flush_o;
  assign br_bus_o.branch_target = rst_i ? '0 : next_pc;
  assign rd_o                   = (is_jump && !rst_i) ? link_pc : '0;

  assign ex_hit = ex_entry.valid && (ex_entry.tag == ex_tag);

  // Training policy: update on hit, allocate on taken miss, ignore not-taken miss
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = ex_entry;
    if (train) begin
      if (ex_hit) begin
        wr_en        = 1'b1;
        wr_entry.cnt = cnt_step(ex_entry.cnt, act_taken);
        if (act_taken) wr_entry.target = act_target;
      end else if (act_taken) begin
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
        wr_entry.tag    = ex_tag;
        wr_entry.target = act_target;
        wr_entry.cnt    = is_jump ? CNT_STRONG_T : CNT_WEAK_T;
      end
    end
  end

`ifdef BRU_STATS_EN
  logic [31:0] branch_cnt_q, mispredict_cnt_q;

  // Count trained branches and trained mispredictions
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else if (train) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (flush_o) mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
    end
  end

  assign branch_cnt_o     = branch_cnt_q;
  assign mispredict_cnt_o = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit (default 32-bit, 64-entry BTB).
module tb_branch_predict_unit;
  import core::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_valid;
  logic [31:0]   f_pc;
  logic          pred_taken;
  logic [31:0]   pred_target;
  logic          ex_valid, ex_stall, ex_pred_taken;
  logic [31:0]   ex_pred_target, rs1, rs2, rd;
  logic          flush;
  pipeline_bus_t bus;
  br_cntrl_bus_t br_bus;
`ifdef BRU_STATS_EN
  logic [31:0]   branch_cnt, mispredict_cnt;
`endif

  int tests    = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .f_valid_i        (f_valid),
    .f_pc_i           (f_pc),
    .pred_taken_o     (pred_taken),
    .pred_target_o    (pred_target),
    .ex_valid_i       (ex_valid),
    .ex_stall_i       (ex_stall),
    .bus_i            (bus),
    .ex_pred_taken_i  (ex_pred_taken),
    .ex_pred_target_i (ex_pred_target),
    .rs1_in_i         (rs1),
    .rs2_in_i         (rs2),
    .rd_o             (rd),
    .flush_o          (flush),
    .br_bus_o         (br_bus)
`ifdef BRU_STATS_EN
    ,
    .branch_cnt_o     (branch_cnt),
    .mispredict_cnt_o (mispredict_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic ex(input logic [4:0] op, input logic [31:0] pc, input logic [31:0] imm,
                    input logic [31:0] a, input logic [31:0] b,
                    input logic pt, input logic [31:0] ptgt);
    ex_valid       = 1'b1;
    bus.is_branch  = 1'b1;
    bus.alu_op     = op;
    bus.pc         = pc;
    bus.imm        = imm;
    rs1            = a;
    rs2            = b;
    ex_pred_taken  = pt;
    ex_pred_target = ptgt;
  endtask

  // Move to the sampling point of the next cycle (away from posedge)
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk_pred(input string tag, input logic t, input logic [31:0] tgt);
    #1;
    check({tag, ".taken"}, {31'd0, pred_taken}, {31'd0, t});
    check({tag, ".target"}, pred_target, tgt);
  endtask

  task automatic chk_ex(input string tag, input logic fl, input logic [31:0] tgt,
                        input logic [31:0] link);
    #1;
    check({tag, ".flush"}, {31'd0, flush}, {31'd0, fl});
    check({tag, ".is_taken"}, {31'd0, br_bus.is_taken}, {31'd0, fl});
    check({tag, ".br_target"}, br_bus.branch_target, tgt);
    check({tag, ".rd"}, rd, link);
  endtask

  initial begin
    rst = 1'b1; f_valid = 1'b1; f_pc = 32'h100;
    ex_stall = 1'b0;
    ex(ALU_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);

    // Reset: outputs held at zero even with a mispredicting branch in execute
    step();
    #1;
    check("rst.flush", {31'd0, flush}, 32'd0);
    check("rst.br_bus", {31'd0, br_bus.is_taken} | br_bus.branch_target, 32'd0);
    check("rst.rd", rd, 32'd0);
    check("rst.pred", {31'd0, pred_taken}, 32'd0);
    step();

    // Cold lookup
    step(); rst = 1'b0; ex_valid = 1'b0;
    chk_pred("cold", 1'b0, 32'h104);

    // First BEQ taken, predicted not-taken
    step(); ex(ALU_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104);
    chk_ex("beq1", 1'b1, 32'h120, 32'd0);

    // Now predicted taken; two more correct taken executions (counter 11)
    step(); ex(ALU_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b1, 32'h120);
    chk_pred("beq2", 1'b1, 32'h120);
    chk_ex("beq2", 1'b0, 32'h120, 32'd0);
    step();
    chk_ex("beq3", 1'b0, 32'h120, 32'd0);

    // Not taken with taken prediction -> counter 10, still predicts taken
    step(); ex(ALU_BEQ, 32'h100, 32'h20, 32'd5, 32'd6, 1'b1, 32'h120);
    chk_ex("beq_nt1", 1'b1, 32'h104, 32'd0);
    step();
    chk_pred("after_nt1", 1'b1, 32'h120);
    chk_ex("beq_nt2", 1'b1, 32'h104, 32'd0);

    // Counter now 01; stalled taken branch must not train for 2 cycles
    step(); ex(ALU_BEQ, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h104); ex_stall = 1'b1;
    chk_pred("after_nt2", 1'b0, 32'h104);
    chk_ex("stall1", 1'b1, 32'h120, 32'd0);
    step();
    chk_pred("stall2", 1'b0, 32'h104);
    step(); ex_stall = 1'b0;
    chk_pred("stall_done", 1'b0, 32'h104);
    step(); ex_valid = 1'b0;
    chk_pred("retrained", 1'b1, 32'h120);

    // Alias: same index, different tag
    step(); f_pc = 32'h200;
    chk_pred("alias", 1'b0, 32'h204);

    // JALR mispredicted, then correctly predicted
    step(); ex(ALU_JALR, 32'h200, 32'd4, 32'h1001, 32'd0, 1'b0, 32'h204);
    chk_ex("jalr1", 1'b1, 32'h1004, 32'h204);
    step(); ex(ALU_JALR, 32'h200, 32'd4, 32'h1001, 32'd0, 1'b1, 32'h1004);
    chk_pred("jalr_pred", 1'b1, 32'h1004);
    chk_ex("jalr2", 1'b0, 32'h1004, 32'h204);

    // Signed vs unsigned compares
    step(); f_pc = 32'h100;
    ex(ALU_BLT, 32'h408, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h448);
    chk_pred("evicted", 1'b0, 32'h104);
    chk_ex("blt", 1'b0, 32'h448, 32'd0);
    step(); ex(ALU_BLTU, 32'h414, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h418);
    chk_ex("bltu", 1'b0, 32'h418, 32'd0);
    step(); ex(ALU_BGE, 32'h414, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h454);
    chk_ex("bge", 1'b1, 32'h418, 32'd0);
    step(); ex(ALU_BGEU, 32'h414, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h418);
    chk_ex("bgeu", 1'b1, 32'h454, 32'd0);
    step(); ex(ALU_BNE, 32'h420, 32'h40, 32'd3, 32'd3, 1'b0, 32'h424);
    chk_ex("bne", 1'b0, 32'h424, 32'd0);
    step(); ex({BRANCH_PRFX, 3'b010}, 32'h600, 32'h40, 32'd3, 32'd3, 1'b1, 32'h640);
    chk_ex("undef_op", 1'b1, 32'h604, 32'd0);

    // Same-cycle lookup and train of index 3 shows the old entry
    step(); f_pc = 32'h10C;
    ex(ALU_JAL, 32'h10C, 32'h100, 32'd0, 32'd0, 1'b0, 32'h110);
    chk_pred("same_cyc", 1'b0, 32'h110);
    chk_ex("jal", 1'b1, 32'h20C, 32'h110);
    step(); ex_valid = 1'b0;
    chk_pred("jal_trained", 1'b1, 32'h20C);
    step(); f_valid = 1'b0;
    chk_pred("f_invalid", 1'b0, 32'h110);

    // Reset during a training cycle
    step(); f_valid = 1'b1; rst = 1'b1;
    ex(ALU_BEQ, 32'h500, 32'h20, 32'd1, 32'd1, 1'b0, 32'h504);
    chk_ex("rst_mid", 1'b0, 32'd0, 32'd0);
    check("rst_mid.pred", {31'd0, pred_taken}, 32'd0);
    step(); rst = 1'b0; ex_valid = 1'b0; f_pc = 32'h500;
    chk_pred("rst_discard", 1'b0, 32'h504);
`ifdef BRU_STATS_EN
    check("stats_rst.branch", branch_cnt, 32'd0);
    check("stats_rst.mispred", mispredict_cnt, 32'd0);
`endif
    step(); f_pc = 32'h10C;
    chk_pred("rst_cleared", 1'b0, 32'h110);

    // One trained mispredict after reset
    step(); f_pc = 32'h500;
    ex(ALU_BEQ, 32'h500, 32'h20, 32'd1, 32'd1, 1'b0, 32'h504);
    chk_ex("post_rst", 1'b1, 32'h520, 32'd0);
    step(); ex_valid = 1'b0;
    chk_pred("post_rst_pred", 1'b1, 32'h520);
`ifdef BRU_STATS_EN
    check("stats.branch", branch_cnt, 32'd1);
    check("stats.mispred", mispredict_cnt, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
